// File: rtl/hazard_ctrl_sb_pkg.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_sb_pkg : shared types, widths and forwarding encodings
// Rev 1.0
// ============================================================================
package hazard_ctrl_sb_pkg;

  localparam int DEF_NUM_SRC      = 3;
  localparam int DEF_NUM_FWD_STG  = 3;
  localparam int DEF_NUM_BANKS    = 2;
  localparam int DEF_MAX_PEND     = 3;
  localparam int DEF_MAX_INFLIGHT = 4;

  localparam int BANK_W    = $clog2(DEF_NUM_BANKS);
  localparam int FWD_SEL_W = $clog2(2*DEF_NUM_FWD_STG+1);

  localparam logic [FWD_SEL_W-1:0] FWD_NONE = '0;
  localparam logic [BANK_W-1:0]    X_REG    = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  function automatic logic [FWD_SEL_W-1:0] fwd_alu(input int s);
    return FWD_SEL_W'(2*s+1);
  endfunction

  function automatic logic [FWD_SEL_W-1:0] fwd_mem(input int s);
    return FWD_SEL_W'(2*s+2);
  endfunction

  // x0 is hard-wired zero; f0 is an ordinary register
  function automatic logic is_valid_dst(input logic [4:0] addr, input logic [BANK_W-1:0] bank);
    return !(bank == X_REG && addr == 5'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sb_pend_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_sb_pend_scoreboard : per-register pending-write counters for
// out-of-order long-latency writeback, plus the global in-flight count
// Rev 1.0
// ============================================================================
module hazard_ctrl_sb_pend_scoreboard
  import hazard_ctrl_sb_pkg::*;
#(
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int NUM_BANKS    = DEF_NUM_BANKS,
  parameter int MAX_PEND     = DEF_MAX_PEND,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_SRC*5-1:0]              src_addr_i,
  input  logic [NUM_SRC*BANK_W-1:0]         src_bank_i,
  input  logic [NUM_SRC-1:0]                src_used_i,
  input  logic [4:0]                        rd_addr_i,
  input  logic [BANK_W-1:0]                 rd_bank_i,
  input  logic                              inc_i,
  input  logic                              wb_valid_i,
  input  logic [4:0]                        wb_addr_i,
  input  logic [BANK_W-1:0]                 wb_bank_i,
  output logic [NUM_SRC-1:0]                src_pend_o,
  output logic                              rd_full_o,
  output logic                              inflight_full_o,
  output logic                              drained_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o
);

  localparam int CNT_W  = $clog2(MAX_PEND+1);
  localparam int INFL_W = $clog2(MAX_INFLIGHT+1);

  logic [CNT_W-1:0]  r_pend_cnt [NUM_BANKS][32];
  logic [INFL_W-1:0] r_inflight;
  logic [INFL_W-1:0] w_inflight_nxt;
  logic              w_dec;

  // Retiring an entry that is already zero is dropped rather than wrapping
  assign w_dec          = wb_valid_i && (r_pend_cnt[wb_bank_i][wb_addr_i] != '0);
  assign w_inflight_nxt = r_inflight + INFL_W'(inc_i) - INFL_W'(w_dec);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < 32; r++)
          r_pend_cnt[b][r] <= '0;
      r_inflight <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < 32; r++)
          r_pend_cnt[b][r] <= r_pend_cnt[b][r]
            + CNT_W'(inc_i && rd_bank_i == BANK_W'(b) && rd_addr_i == 5'(r))
            - CNT_W'(w_dec && wb_bank_i == BANK_W'(b) && wb_addr_i == 5'(r));
      r_inflight <= w_inflight_nxt;
    end
  end

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign src_pend_o[i] = src_used_i[i]
        && is_valid_dst(src_addr_i[i*5 +: 5], src_bank_i[i*BANK_W +: BANK_W])
        && (r_pend_cnt[src_bank_i[i*BANK_W +: BANK_W]][src_addr_i[i*5 +: 5]] != '0);
    end
  endgenerate

  assign rd_full_o       = (r_pend_cnt[rd_bank_i][rd_addr_i] == CNT_W'(MAX_PEND));
  assign inflight_full_o = (r_inflight == INFL_W'(MAX_INFLIGHT));
  assign drained_o       = (w_inflight_nxt == '0);
  assign inflight_o      = r_inflight;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_sb : operand forwarding, stall/flush chain, long-latency
// scoreboard and precise-trap drain sequencer for a 5-stage pipeline
// Rev 1.0
// ============================================================================
module hazard_ctrl_sb
  import hazard_ctrl_sb_pkg::*;
#(
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int NUM_FWD_STG  = DEF_NUM_FWD_STG,
  parameter int NUM_BANKS    = DEF_NUM_BANKS,
  parameter int MAX_PEND     = DEF_MAX_PEND,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_SRC*5-1:0]              src_addr_id_i,
  input  logic [NUM_SRC*BANK_W-1:0]         src_bank_id_i,
  input  logic [NUM_SRC-1:0]                src_used_id_i,
  input  logic [NUM_FWD_STG*5-1:0]          rd_addr_stg_i,
  input  logic [NUM_FWD_STG*BANK_W-1:0]     rd_bank_stg_i,
  input  logic [NUM_FWD_STG-1:0]            alu_wen_stg_i,
  input  logic [NUM_FWD_STG-1:0]            mem_wen_stg_i,
  output logic [NUM_SRC*FWD_SEL_W-1:0]      fwd_sel_o,
  input  logic                              issue_id_i,
  input  logic                              issue_long_id_i,
  input  logic [4:0]                        rd_addr_id_i,
  input  logic [BANK_W-1:0]                 rd_bank_id_i,
  input  logic                              rd_wen_id_i,
  input  logic                              lu_wb_valid_i,
  input  logic [4:0]                        lu_wb_addr_i,
  input  logic [BANK_W-1:0]                 lu_wb_bank_i,
  input  logic                              ex_busy_i,
  input  logic                              mem_busy_i,
  input  logic                              valid_if_i,
  input  logic                              jump_id_i,
  input  logic                              branch_ex_i,
  input  logic                              trap_id_i,
  output logic                              stall_if_o,
  output logic                              stall_id_o,
  output logic                              stall_ex_o,
  output logic                              stall_mem_o,
  output logic                              flush_id_o,
  output logic                              flush_ex_o,
  output logic                              flush_wb_o,
  output logic                              trap_redirect_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o
);

  trap_state_t        r_state;
  trap_state_t        w_state_nxt;
  logic               w_load_use;
  logic [NUM_SRC-1:0] w_src_pend;
  logic               w_rd_full;
  logic               w_infl_full;
  logic               w_drained;
  logic               w_long_req;
  logic               w_inc;

  // Stages are scanned oldest-first so the youngest (lowest index) match wins
  always_comb begin
    fwd_sel_o  = '0;
    w_load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = NUM_FWD_STG-1; s >= 0; s--) begin
        if (src_used_id_i[i]
            && src_addr_id_i[i*5 +: 5] == rd_addr_stg_i[s*5 +: 5]
            && src_bank_id_i[i*BANK_W +: BANK_W] == rd_bank_stg_i[s*BANK_W +: BANK_W]
            && is_valid_dst(rd_addr_stg_i[s*5 +: 5], rd_bank_stg_i[s*BANK_W +: BANK_W])
            && (alu_wen_stg_i[s] || mem_wen_stg_i[s])) begin
          if (alu_wen_stg_i[s]) begin
            fwd_sel_o[i*FWD_SEL_W +: FWD_SEL_W] = fwd_alu(s);
          end else if (s == 0) begin
            fwd_sel_o[i*FWD_SEL_W +: FWD_SEL_W] = FWD_NONE;
            w_load_use                          = 1'b1;
          end else begin
            fwd_sel_o[i*FWD_SEL_W +: FWD_SEL_W] = fwd_mem(s);
          end
        end
      end
    end
  end

  hazard_ctrl_sb_pend_scoreboard #(
    .NUM_SRC      (NUM_SRC),
    .NUM_BANKS    (NUM_BANKS),
    .MAX_PEND     (MAX_PEND),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_pend_scoreboard (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .src_addr_i      (src_addr_id_i),
    .src_bank_i      (src_bank_id_i),
    .src_used_i      (src_used_id_i),
    .rd_addr_i       (rd_addr_id_i),
    .rd_bank_i       (rd_bank_id_i),
    .inc_i           (w_inc),
    .wb_valid_i      (lu_wb_valid_i),
    .wb_addr_i       (lu_wb_addr_i),
    .wb_bank_i       (lu_wb_bank_i),
    .src_pend_o      (w_src_pend),
    .rd_full_o       (w_rd_full),
    .inflight_full_o (w_infl_full),
    .drained_o       (w_drained),
    .inflight_o      (inflight_o)
  );

  assign w_long_req  = issue_id_i & issue_long_id_i & rd_wen_id_i;
  assign stall_mem_o = mem_busy_i;
  assign stall_ex_o  = stall_mem_o | ex_busy_i;
  assign stall_id_o  = stall_ex_o | w_load_use | (|w_src_pend)
                     | (w_long_req & (w_rd_full | w_infl_full))
                     | (r_state != IDLE);
  assign w_inc       = w_long_req & ~stall_id_o;

  assign stall_if_o  = stall_id_o | (~valid_if_i & ~(branch_ex_i | jump_id_i | trap_id_i));
  assign flush_wb_o  = stall_mem_o;
  assign flush_ex_o  = stall_ex_o | branch_ex_i | stall_id_o;
  assign flush_id_o  = flush_ex_o | jump_id_i | stall_if_o | trap_redirect_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // DRAIN exits in the cycle the last outstanding write retires
  always_comb begin
    w_state_nxt     = r_state;
    trap_redirect_o = 1'b0;
    case (r_state)
      IDLE:     if (trap_id_i && !branch_ex_i) w_state_nxt = DRAIN;
      DRAIN:    if (w_drained) w_state_nxt = REDIRECT;
      REDIRECT: begin
        trap_redirect_o = 1'b1;
        w_state_nxt     = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
